// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path.
// Holds the default address/data widths, the hard-wired zero register
// address, and the fixed requester slot assignments used by the
// writeback arbiter (ALU, load unit, mul/div unit).
package rf_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  // Register 0 reads as zero; writes to it are swallowed.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Requester slot on the writeback arbiter.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_MDU  = 2'd2
  } wb_src_e;

endpackage : rf_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts one past the last winner (ptr) and wraps, so the
// most recently served requester has the lowest priority next time.
// Ports:
//   req   in  N       request vector
//   ptr   in  IDX_W   index of the previous winner
//   grant out N       one-hot grant, zero when no request is pending
//   idx   out IDX_W   index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int N = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the requesters from ptr+1 around to ptr, taking the first valid one.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Up to N_REQ requesters (ALU=0, load=1, mul/div=2) compete round-robin;
// the winner's write is registered and reaches the register file one
// clock after acceptance. Writes to register 0 are accepted but never
// raise reg_write.
// Optional feature (macro WB_BYPASS_EN): adds a two-port forwarding
// lookup so decode can pick up the write that is still in flight.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             hold from the hazard unit, blocks all grants
//   req_valid/addr/data  packed per-requester write requests
//   req_ready         one-hot acceptance this cycle
//   reg_write, write_addr, write_data  registered register-file write
//   busy              a valid request is left waiting this cycle
//   byp_addr1/2, byp_hit1/2, byp_data  forwarding lookup (WB_BYPASS_EN)
module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DATA_W = rf_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    reg_write,
  output logic [ADDR_W-1:0]       write_addr,
  output logic [DATA_W-1:0]       write_data,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0]       byp_addr1,
  input  logic [ADDR_W-1:0]       byp_addr2,
  output logic                    byp_hit1,
  output logic                    byp_hit2,
  output logic [DATA_W-1:0]       byp_data,
`endif
  output logic                    busy
);

  import rf_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic [N_REQ-1:0]  grant_s;
  logic [IDX_W-1:0]  win_idx_s;
  logic              xfer_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_data_s;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant_s),
    .idx   (win_idx_s)
  );

  // Grants are suppressed during reset and stall so nothing is accepted.
  always_comb begin
    if (rst || stall) begin
      req_ready = '0;
    end else begin
      req_ready = grant_s;
    end
  end

  // Any valid requester left without a grant keeps busy high.
  always_comb begin
    if (rst) begin
      busy = 1'b0;
    end else begin
      busy = |(req_valid & ~req_ready);
    end
  end

  // Select the accepted request's address and data.
  always_comb begin
    win_addr_s = '0;
    win_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        win_addr_s = req_addr[i*ADDR_W +: ADDR_W];
        win_data_s = req_data[i*DATA_W +: DATA_W];
      end else begin
        win_addr_s = win_addr_s;
      end
    end
  end

  assign xfer_s = |req_ready;

  // Next-state: capture the winner, hold address/data otherwise.
  always_comb begin
    ptr_d        = ptr_q;
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (xfer_s) begin
      ptr_d        = win_idx_s;
      reg_write_d  = (win_addr_s != ADDR_W'(REG_ZERO));
      write_addr_d = win_addr_s;
      write_data_d = win_data_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= IDX_W'(N_REQ - 1);
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;

`ifdef WB_BYPASS_EN
  // Register 0 never forwards: it is never written.
  assign byp_hit1 = reg_write_q && (write_addr_q == byp_addr1) && (byp_addr1 != ADDR_W'(REG_ZERO));
  assign byp_hit2 = reg_write_q && (write_addr_q == byp_addr2) && (byp_addr2 != ADDR_W'(REG_ZERO));
  assign byp_data = write_data_q;
`endif

endmodule : regfile_wb_arbiter

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port among N_REQ writeback requesters: ALU (0), load unit (1) and mul/div unit (2).
- Round-robin arbitration, one grant per cycle.
- Registers the winning write onto reg_write/write_addr/write_data, so the write lands on the register file one clock later.
- Sits between the execute/memory stages and register_file.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard-unit hold; no grants while high
req_valid  in  N_REQ  per-requester write request
req_addr  in  N_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  one-hot grant; request accepted this cycle
reg_write  out  1  register file write enable (registered)
write_addr  out  ADDR_W  register file write address (registered)
write_data  out  DATA_W  register file write data (registered)
busy  out  1  high when any req_valid is high and not granted this cycle

Behaviour:
- Reset: clk single clock; rst synchronous, active-high.
  - Sampled at posedge: reg_write=0, write_addr=0, write_data=0, round-robin pointer=N_REQ-1, so requester 0 has first priority.
  - req_ready=0 and busy=0 while rst is high.
  - Reset mid-operation discards any registered write; an asserted reg_write is cleared on that edge.
- Arbitration (combinational):
  - Search starts at requester (ptr+1) mod N_REQ and wraps.
  - First requester with req_valid=1 wins.
  - req_ready is one-hot or zero; it depends on req_valid, stall and ptr only.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Requesters hold valid, addr and data stable until accepted.
  - Dropping valid before acceptance is permitted; the request is then simply lost.
- Pointer: on a transfer, ptr <= winner index. With no transfer, ptr holds.
- Output register, 1-cycle latency:
  - On a transfer, write_addr/write_data <= winner's addr/data.
  - reg_write <= (winner addr != 0).
  - With no transfer, reg_write <= 0 and write_addr/write_data hold their last value.
- Register 0: writes to reg 0 are accepted (ready asserted, pointer advances) but never drive reg_write=1.
- stall: forces req_ready=0 and reg_write <= 0 next edge; ptr holds.
- Simultaneous requests: exactly one is granted per cycle. With all valid continuously, grants rotate 0,1,2,0,...; no requester waits more than N_REQ-1 cycles.
- busy = |req_valid && no grant to every valid requester. That is, busy is high when stall is high, or when more than one requester is valid.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: adds ports byp_addr1/byp_addr2 (in, ADDR_W) and byp_hit1/byp_hit2 (out, 1), plus byp_data (out, DATA_W) = write_data.
  - byp_hitN = reg_write && (write_addr == byp_addrN) && (byp_addrN != 0).
  - Lets the decode stage forward the in-flight write that register_file has not yet committed.
- Not defined: ports absent, no extra logic.

Decomposition:
- Shared package/header rf_pkg: ADDR_W=5, DATA_W=32, REG_ZERO=5'd0, requester index constants WB_ALU=0, WB_LOAD=1, WB_MDU=2.
- One sub-module, rr_arbiter (N parameter): req vector, ptr -> one-hot grant and winner index; reusable elsewhere.
- Output register and bypass stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles with all req_valid=1 -> req_ready=0, reg_write=0, write_addr=0; first grant after release goes to requester 0.
- Single write: req 1 valid, addr 5, data 0xDEADBEEF -> req_ready=3'b010 that cycle; next cycle reg_write=1, write_addr=5, write_data=0xDEADBEEF; then reg_write=0.
- Round robin: all three valid for 6 cycles, addrs 1/2/3 -> grants 0,1,2,0,1,2; write_addr sequence 1,2,3,1,2,3 each one cycle later; busy=1 throughout.
- Reg 0: req 0 writes addr 0, data 0x12345678 -> req_ready[0]=1, reg_write stays 0; with register_file attached, reg 0 still reads 0.
- Stall: req 2 valid, stall=1 for 3 cycles -> no ready, reg_write=0, busy=1; stall drops -> grant to 2 next cycle, write one cycle after.
- WB_BYPASS_EN: grant addr 10, data 0xCAFECAFE; byp_addr1=10, byp_addr2=0 in the write cycle -> byp_hit1=1, byp_hit2=0, byp_data=0xCAFECAFE.
